// File: rtl/window_acc_pkg.sv
// Shared types and width helpers for the window accumulator.
`timescale 1ns/1ps
package window_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Width of a counter that must represent 0..length inclusive.
    function automatic int count_width(input int length);
        return $clog2(length + 1);
    endfunction

    // Default accumulator width: wide enough that length full-scale samples never wrap.
    function automatic int acc_width(input int width, input int length);
        return width + $clog2(length);
    endfunction

endpackage

// File: rtl/window_accumulator_if.sv
// Stream bundle around the window accumulator. Optional overflow_o appears
// only when WINDOW_ACC_SATURATE_EN is defined.
`timescale 1ns/1ps
interface window_accumulator_if
    import window_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10,
    parameter int CNT_WIDTH = 3
) ();

    // Stream semantics: data_i is meaningful only while valid_i is high and is
    // always consumed (no backpressure); valid_o is a one-cycle pulse marking a
    // new data_o, which otherwise holds the last completed window sum.
    logic                 clear_i;
    logic [WIDTH-1:0]     data_i;
    logic                 valid_i;
    logic [ACC_WIDTH-1:0] data_o;
    logic                 valid_o;
    logic [CNT_WIDTH-1:0] count_o;
    state_e               dbg_state;
`ifdef WINDOW_ACC_SATURATE_EN
    logic                 overflow_o;
`endif

    modport master (
        output clear_i, data_i, valid_i,
`ifdef WINDOW_ACC_SATURATE_EN
        input  overflow_o,
`endif
        input  data_o, valid_o, count_o, dbg_state
    );

    modport slave (
        input  clear_i, data_i, valid_i,
`ifdef WINDOW_ACC_SATURATE_EN
        output overflow_o,
`endif
        output data_o, valid_o, count_o, dbg_state
    );

endinterface

// File: rtl/window_accumulator.sv
// Sums LENGTH consecutive valid samples and pulses the result out one cycle later.
// Define WINDOW_ACC_SATURATE_EN for saturating adds plus an overflow_o flag.
`timescale 1ns/1ps
module window_accumulator
    import window_acc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LENGTH    = 4,
    parameter int ACC_WIDTH = acc_width(WIDTH, LENGTH)
) (
    input logic                 clk,
    input logic                 rstn,
    window_accumulator_if.slave bus
);

    localparam int CNT_W = count_width(LENGTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

    state_e               state, state_n;
    logic [ACC_WIDTH-1:0] acc, acc_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]     sample;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 done;
    logic [ACC_WIDTH-1:0] data_q;
    logic                 valid_q;

    assign sample = bus.data_i;
    assign ext    = ACC_WIDTH'(sample);

`ifdef WINDOW_ACC_SATURATE_EN
    logic                 carry;
    logic                 ovf, ovf_n;
    logic                 ovf_q;

    // Returns {carry, result}; the result clamps to all-ones on carry-out.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[ACC_WIDTH]) begin
            return {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return wide;
    endfunction

    assign {carry, sum} = sat_add(acc, ext);
`else
    assign sum = acc + ext;
`endif

    // Clear wins over completion; a valid sample alongside clear opens a new window.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        done    = 1'b0;
`ifdef WINDOW_ACC_SATURATE_EN
        ovf_n   = ovf;
`endif
        if (bus.clear_i) begin
            if (bus.valid_i) begin
                acc_n   = ext;
                cnt_n   = CNT_W'(1);
                state_n = ACCUM;
            end else begin
                acc_n   = '0;
                cnt_n   = '0;
                state_n = IDLE;
            end
`ifdef WINDOW_ACC_SATURATE_EN
            ovf_n = 1'b0;
`endif
        end else if (bus.valid_i) begin
            case (state)
                IDLE: begin
                    acc_n   = ext;
                    cnt_n   = CNT_W'(1);
                    state_n = ACCUM;
`ifdef WINDOW_ACC_SATURATE_EN
                    ovf_n   = 1'b0;
`endif
                end
                ACCUM: begin
                    if (cnt == LAST_IDX) begin
                        done    = 1'b1;
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
`ifdef WINDOW_ACC_SATURATE_EN
                        ovf_n   = 1'b0;
`endif
                    end else begin
                        acc_n = sum;
                        cnt_n = cnt + CNT_W'(1);
`ifdef WINDOW_ACC_SATURATE_EN
                        ovf_n = ovf | carry;
`endif
                    end
                end
                default: begin
                    state_n = IDLE;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            valid_q <= done;
            if (done) begin
                data_q <= sum;
            end
        end
    end

`ifdef WINDOW_ACC_SATURATE_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ovf   <= ovf_n;
            ovf_q <= done & (ovf | carry);
        end
    end

    assign bus.overflow_o = ovf_q;
`endif

    assign bus.data_o    = data_q;
    assign bus.valid_o   = valid_q;
    assign bus.count_o   = cnt;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_window_accumulator.sv
// Randomized scoreboard bench for window_accumulator; model sums whole windows
// with plain integer arithmetic.
`timescale 1ns/1ps
module tb_window_accumulator;
    import window_acc_pkg::*;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 4;
`ifdef WINDOW_ACC_SATURATE_EN
    localparam int ACC_W  = 9;
`else
    localparam int ACC_W  = 10;
`endif
    localparam int CNT_W  = 3;
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    window_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_W), .CNT_WIDTH(CNT_W)) bus ();

    window_accumulator #(.WIDTH(WIDTH), .LENGTH(LENGTH), .ACC_WIDTH(ACC_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [ACC_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic             exp_ovf_q[$];

    longint           win_sum    = 0;
    int               win_cnt    = 0;
    logic [ACC_W-1:0] model_data = '0;
    int               ncyc       = 0;
    bit               check_en   = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, ncyc);
        end
    endtask

    // One clock of stimulus; the model advances at the same edge the DUT does.
    task automatic step(input logic rst_n, input logic clr, input logic vld,
                        input logic [WIDTH-1:0] d);
        longint res;
        bit     ovf;
        rstn        = rst_n;
        bus.clear_i = clr;
        bus.valid_i = vld;
        bus.data_i  = d;
        @(posedge clk);
        if (!rst_n) begin
            win_sum    = 0;
            win_cnt    = 0;
            model_data = '0;
        end else if (clr) begin
            win_sum = vld ? longint'(d) : 0;
            win_cnt = vld ? 1 : 0;
        end else if (vld) begin
            win_sum += longint'(d);
            win_cnt++;
            if (win_cnt == LENGTH) begin
`ifdef WINDOW_ACC_SATURATE_EN
                ovf = win_sum > ACC_MAX;
                res = ovf ? ACC_MAX : win_sum;
`else
                ovf = 1'b0;
                res = win_sum % (ACC_MAX + 1);
`endif
                exp_q.push_back(ACC_W'(res));
                exp_ovf_q.push_back(ovf);
                exp_cyc_q.push_back(ncyc + 1);
                model_data = ACC_W'(res);
                win_sum    = 0;
                win_cnt    = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
    endtask

    // Monitor: pops the scoreboard whenever a pulse is due and checks held outputs.
    always @(negedge clk) begin
        bit               pulse;
        logic [ACC_W-1:0] d;
        logic             o;
        ncyc++;
        if (check_en) begin
            pulse = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == ncyc);
            check("valid_o", longint'(bus.valid_o), longint'(pulse));
            if (pulse) begin
                d = exp_q.pop_front();
                o = exp_ovf_q.pop_front();
                void'(exp_cyc_q.pop_front());
                check("data_o_pulse", longint'(bus.data_o), longint'(d));
`ifdef WINDOW_ACC_SATURATE_EN
                check("overflow_o_pulse", longint'(bus.overflow_o), longint'(o));
`endif
            end else begin
`ifdef WINDOW_ACC_SATURATE_EN
                check("overflow_o_idle", longint'(bus.overflow_o), 0);
`endif
            end
            check("data_o_hold", longint'(bus.data_o), longint'(model_data));
            check("count_o", longint'(bus.count_o), longint'(win_cnt));
            check("state_idle", longint'(bus.dbg_state == IDLE), longint'(win_cnt == 0));
        end
    end

    initial begin
        bus.clear_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check_en = 1'b1;
        idle(1);

        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
        idle(3);

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'd255);
            idle($urandom_range(0, 3));
        end
        idle(3);

        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
        idle(2);

        step(1'b1, 1'b0, 1'b1, 8'd5);
        step(1'b1, 1'b0, 1'b1, 8'd6);
        step(1'b1, 1'b1, 1'b1, 8'd7);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'd1);
        idle(2);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'd9);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'd2);
        idle(2);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'd3);
        step(1'b1, 1'b1, 1'b1, 8'd4);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'd200);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 6),
                 8'($urandom_range(0, 255)));
        end
        idle(4);

        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
